// File: rtl/obi_mem_arbiter_if.sv
// OBI request/response bundle shared by the two requesters and the memory
// side of obi_mem_arbiter. "master" is the side that issues requests and
// "slave" is the side that grants them and returns responses.
interface obi_mem_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    req;
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    we;
    logic [DATA_WIDTH/8-1:0] be;
    logic [DATA_WIDTH-1:0]   wdata;
    logic                    gnt;
    logic                    rvalid;
    logic [DATA_WIDTH-1:0]   rdata;

    modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/obi_mem_arbiter.sv
// Two-to-one OBI arbiter: instruction fetch (requester 0) and LSU
// (requester 1) share one memory port. Round-robin selection, lock while a
// request waits for grant, and an in-order owner queue that steers each
// response back to the requester that issued it.
// Optional macro OBI_ARB_PROTO_CHECK_EN enables the sticky protocol_err_o
// flag (stray rvalid, or locked requester dropping req / changing addr).
// The instr port's we/be/wdata are ignored: fetches always go out as
// full-word reads.
module obi_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    obi_mem_arbiter_if.slave   instr_bus,
    obi_mem_arbiter_if.slave   data_bus,
    obi_mem_arbiter_if.master  mem_bus,
    output logic               protocol_err_o
);
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;
    localparam logic       SRC_INSTR = 1'b0;
    localparam logic       SRC_DATA  = 1'b1;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

    logic [0:0]                 state_q, state_d;
    logic                       locked_src_q, locked_src_d;
    logic                       rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]           count_q, count_d, count_after_pop_s;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [MAX_OUTSTANDING-1:0] owner_q;
    logic                       err_q, err_d;

    logic pop_s, push_s, full_s, head_s;
    logic sel_s, sel_req_s, req_out_s, accept_s;
    logic locked_req_s, lock_violation_s;
    logic [ADDR_WIDTH-1:0] sel_addr_s;

`ifdef OBI_ARB_PROTO_CHECK_EN
    logic [ADDR_WIDTH-1:0] locked_addr_q, locked_addr_d;
`endif

    // Arbitration and handshake decode: queue occupancy, lock release, selection.
    always_comb begin
        pop_s             = mem_bus.rvalid && (count_q != {CNT_W{1'b0}});
        head_s            = owner_q[rd_ptr_q];
        count_after_pop_s = count_q - CNT_W'(pop_s);
        // A slot freed by this cycle's response may be reused immediately.
        full_s            = (count_after_pop_s == CNT_MAX);

        locked_req_s = locked_src_q ? data_bus.req : instr_bus.req;
`ifdef OBI_ARB_PROTO_CHECK_EN
        lock_violation_s = (state_q == ST_LOCKED) &&
                           (!locked_req_s ||
                            ((locked_src_q ? data_bus.addr : instr_bus.addr) != locked_addr_q));
`else
        // Withdrawn request still releases the lock so the port cannot hang.
        lock_violation_s = (state_q == ST_LOCKED) && !locked_req_s;
`endif

        if ((state_q == ST_LOCKED) && !lock_violation_s) begin
            sel_s = locked_src_q;
        end else if (instr_bus.req && data_bus.req) begin
            sel_s = rr_ptr_q;
        end else if (data_bus.req) begin
            sel_s = SRC_DATA;
        end else begin
            sel_s = SRC_INSTR;
        end

        sel_req_s  = sel_s ? data_bus.req : instr_bus.req;
        sel_addr_s = sel_s ? data_bus.addr : instr_bus.addr;
        req_out_s  = rst_ni && sel_req_s && !full_s;
        accept_s   = req_out_s && mem_bus.gnt;
        push_s     = accept_s;
    end

    // Next-state computation for FSM, round-robin pointer, queue and error flag.
    always_comb begin
        state_d      = state_q;
        locked_src_d = locked_src_q;
        rr_ptr_d     = rr_ptr_q;
        if (accept_s) begin
            state_d  = ST_IDLE;
            rr_ptr_d = ~sel_s;
        end else if (req_out_s) begin
            state_d      = ST_LOCKED;
            locked_src_d = sel_s;
        end else begin
            state_d = ST_IDLE;
        end

        count_d = count_after_pop_s + CNT_W'(push_s);

        if (push_s) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? {PTR_W{1'b0}} : wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? {PTR_W{1'b0}} : rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

`ifdef OBI_ARB_PROTO_CHECK_EN
        locked_addr_d = (req_out_s && !mem_bus.gnt) ? sel_addr_s : locked_addr_q;
        err_d = err_q ||
                (mem_bus.rvalid && (count_q == {CNT_W{1'b0}})) ||
                lock_violation_s;
`else
        err_d = 1'b0;
`endif
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            locked_src_q  <= SRC_INSTR;
            rr_ptr_q      <= SRC_INSTR;
            count_q       <= {CNT_W{1'b0}};
            wr_ptr_q      <= {PTR_W{1'b0}};
            rd_ptr_q      <= {PTR_W{1'b0}};
            owner_q       <= {MAX_OUTSTANDING{1'b0}};
            err_q         <= 1'b0;
`ifdef OBI_ARB_PROTO_CHECK_EN
            locked_addr_q <= {ADDR_WIDTH{1'b0}};
`endif
        end else begin
            state_q      <= state_d;
            locked_src_q <= locked_src_d;
            rr_ptr_q     <= rr_ptr_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            err_q        <= err_d;
            if (push_s) begin
                owner_q[wr_ptr_q] <= sel_s;
            end
`ifdef OBI_ARB_PROTO_CHECK_EN
            locked_addr_q <= locked_addr_d;
`endif
        end
    end

    // Memory side mirrors the selected requester; fetches are full-word reads.
    assign mem_bus.req   = req_out_s;
    assign mem_bus.addr  = rst_ni ? sel_addr_s : {ADDR_WIDTH{1'b0}};
    assign mem_bus.we    = rst_ni && sel_s && data_bus.we;
    assign mem_bus.be    = !rst_ni ? {(DATA_WIDTH/8){1'b0}} :
                           (sel_s ? data_bus.be : {(DATA_WIDTH/8){1'b1}});
    assign mem_bus.wdata = (rst_ni && sel_s) ? data_bus.wdata : {DATA_WIDTH{1'b0}};

    assign instr_bus.gnt = accept_s && (sel_s == SRC_INSTR);
    assign data_bus.gnt  = accept_s && (sel_s == SRC_DATA);

    // Responses go to the owner at the queue head; data is broadcast.
    assign instr_bus.rvalid = pop_s && (head_s == SRC_INSTR);
    assign data_bus.rvalid  = pop_s && (head_s == SRC_DATA);
    assign instr_bus.rdata  = rst_ni ? mem_bus.rdata : {DATA_WIDTH{1'b0}};
    assign data_bus.rdata   = rst_ni ? mem_bus.rdata : {DATA_WIDTH{1'b0}};

    assign protocol_err_o = err_q;
endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Directed testbench for obi_mem_arbiter. Inputs change on the falling edge,
// outputs are sampled 1 ns later, state advances on the rising edge.
module tb_obi_mem_arbiter;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic perr;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    obi_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) instr_if ();
    obi_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) data_if ();
    obi_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

    obi_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(2)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .instr_bus      (instr_if),
        .data_bus       (data_if),
        .mem_bus        (mem_if),
        .protocol_err_o (perr)
    );

    task automatic idle_inputs();
        instr_if.req = 1'b0; instr_if.addr = 32'h0; instr_if.we = 1'b0;
        instr_if.be = 4'h0; instr_if.wdata = 32'h0;
        data_if.req = 1'b0; data_if.addr = 32'h0; data_if.we = 1'b0;
        data_if.be = 4'h0; data_if.wdata = 32'h0;
        mem_if.gnt = 1'b0; mem_if.rvalid = 1'b0; mem_if.rdata = 32'h0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        #2;
        instr_if.req = 1'b1; instr_if.addr = 32'h44; mem_if.gnt = 1'b1;
        mem_if.rvalid = 1'b1; mem_if.rdata = 32'hA5A5A5A5;
        #1;
        checks++; if (mem_if.req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %0h exp 0", mem_if.req); end
        checks++; if (mem_if.addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %0h exp 0", mem_if.addr); end
        checks++; if (mem_if.be !== 4'h0) begin errors++; $display("FAIL reset_mem_be got %0h exp 0", mem_if.be); end
        checks++; if (instr_if.gnt !== 1'b0) begin errors++; $display("FAIL reset_instr_gnt got %0h exp 0", instr_if.gnt); end
        checks++; if (instr_if.rvalid !== 1'b0 || data_if.rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %0h/%0h exp 0/0", instr_if.rvalid, data_if.rvalid); end
        checks++; if (instr_if.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %0h exp 0", instr_if.rdata); end
        checks++; if (perr !== 1'b0) begin errors++; $display("FAIL reset_perr got %0h exp 0", perr); end
    endtask

    task automatic test_single_fetch();
        apply_reset();
        @(negedge clk);
        instr_if.req = 1'b1; instr_if.addr = 32'h180; mem_if.gnt = 1'b1;
        #1;
        checks++; if (mem_if.req !== 1'b1) begin errors++; $display("FAIL fetch_mem_req got %0h exp 1", mem_if.req); end
        checks++; if (mem_if.addr !== 32'h180) begin errors++; $display("FAIL fetch_mem_addr got %0h exp 180", mem_if.addr); end
        checks++; if (mem_if.be !== 4'hF || mem_if.we !== 1'b0) begin errors++; $display("FAIL fetch_be_we got %0h/%0h exp f/0", mem_if.be, mem_if.we); end
        checks++; if (instr_if.gnt !== 1'b1 || data_if.gnt !== 1'b0) begin errors++; $display("FAIL fetch_gnt got %0h/%0h exp 1/0", instr_if.gnt, data_if.gnt); end
        @(negedge clk);
        instr_if.req = 1'b0; mem_if.gnt = 1'b0; mem_if.rvalid = 1'b1; mem_if.rdata = 32'hDEADBEEF;
        #1;
        checks++; if (instr_if.rvalid !== 1'b1 || data_if.rvalid !== 1'b0) begin errors++; $display("FAIL fetch_rvalid got %0h/%0h exp 1/0", instr_if.rvalid, data_if.rvalid); end
        checks++; if (instr_if.rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_rdata got %0h exp deadbeef", instr_if.rdata); end
        @(negedge clk);
        mem_if.rvalid = 1'b0;
        #1;
        checks++; if (instr_if.rvalid !== 1'b0) begin errors++; $display("FAIL fetch_rvalid_clear got %0h exp 0", instr_if.rvalid); end
    endtask

    task automatic test_contention();
        logic       odd;
        logic [31:0] exp_addr, exp_wdata;
        logic [3:0]  exp_be;
        apply_reset();
        instr_if.addr = 32'h100;
        data_if.addr = 32'h2000; data_if.we = 1'b1; data_if.be = 4'h3; data_if.wdata = 32'h55;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            instr_if.req = 1'b1; data_if.req = 1'b1; mem_if.gnt = 1'b1;
            mem_if.rvalid = (i > 0); mem_if.rdata = 32'h0 + i;
            #1;
            odd = (i % 2) == 1;
            exp_addr  = odd ? 32'h2000 : 32'h100;
            exp_wdata = odd ? 32'h55 : 32'h0;
            exp_be    = odd ? 4'h3 : 4'hF;
            checks++; if (instr_if.gnt !== !odd || data_if.gnt !== odd) begin errors++; $display("FAIL rr_gnt[%0d] got %0h/%0h exp %0h/%0h", i, instr_if.gnt, data_if.gnt, !odd, odd); end
            checks++; if (mem_if.we !== odd || mem_if.addr !== exp_addr) begin errors++; $display("FAIL rr_we_addr[%0d] got %0h/%0h exp %0h/%0h", i, mem_if.we, mem_if.addr, odd, exp_addr); end
            checks++; if (mem_if.be !== exp_be || mem_if.wdata !== exp_wdata) begin errors++; $display("FAIL rr_be_wdata[%0d] got %0h/%0h exp %0h/%0h", i, mem_if.be, mem_if.wdata, exp_be, exp_wdata); end
            checks++; if (instr_if.rvalid !== (i == 1 || i == 3) || data_if.rvalid !== (i == 2)) begin errors++; $display("FAIL rr_rvalid[%0d] got %0h/%0h exp %0h/%0h", i, instr_if.rvalid, data_if.rvalid, (i == 1 || i == 3), (i == 2)); end
        end
        @(negedge clk);
        instr_if.req = 1'b0; data_if.req = 1'b0; mem_if.gnt = 1'b0; mem_if.rvalid = 1'b1;
        #1;
        checks++; if (data_if.rvalid !== 1'b1 || instr_if.rvalid !== 1'b0) begin errors++; $display("FAIL rr_drain got %0h/%0h exp 0/1", instr_if.rvalid, data_if.rvalid); end
    endtask

    task automatic test_lock();
        apply_reset();
        @(negedge clk);
        data_if.req = 1'b1; data_if.addr = 32'h1000_0000; data_if.be = 4'hF; mem_if.gnt = 1'b0;
        #1;
        checks++; if (mem_if.addr !== 32'h1000_0000 || data_if.gnt !== 1'b0) begin errors++; $display("FAIL lock_first got %0h/%0h exp 10000000/0", mem_if.addr, data_if.gnt); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            instr_if.req = 1'b1; instr_if.addr = 32'h200;
            #1;
            checks++; if (mem_if.addr !== 32'h1000_0000 || mem_if.req !== 1'b1) begin errors++; $display("FAIL lock_hold[%0d] got %0h/%0h exp 10000000/1", i, mem_if.addr, mem_if.req); end
            checks++; if (instr_if.gnt !== 1'b0 || data_if.gnt !== 1'b0) begin errors++; $display("FAIL lock_nognt[%0d] got %0h/%0h exp 0/0", i, instr_if.gnt, data_if.gnt); end
        end
        @(negedge clk);
        mem_if.gnt = 1'b1;
        #1;
        checks++; if (data_if.gnt !== 1'b1 || instr_if.gnt !== 1'b0 || mem_if.addr !== 32'h1000_0000) begin errors++; $display("FAIL lock_grant got %0h/%0h/%0h exp 1/0/10000000", data_if.gnt, instr_if.gnt, mem_if.addr); end
        @(negedge clk);
        data_if.req = 1'b0;
        #1;
        checks++; if (instr_if.gnt !== 1'b1 || mem_if.addr !== 32'h200) begin errors++; $display("FAIL lock_next got %0h/%0h exp 1/200", instr_if.gnt, mem_if.addr); end
        @(negedge clk);
        instr_if.req = 1'b0; mem_if.gnt = 1'b0; mem_if.rvalid = 1'b1;
        #1;
        checks++; if (data_if.rvalid !== 1'b1 || instr_if.rvalid !== 1'b0) begin errors++; $display("FAIL lock_resp0 got %0h/%0h exp 0/1", instr_if.rvalid, data_if.rvalid); end
        @(negedge clk);
        #1;
        checks++; if (instr_if.rvalid !== 1'b1 || data_if.rvalid !== 1'b0) begin errors++; $display("FAIL lock_resp1 got %0h/%0h exp 1/0", instr_if.rvalid, data_if.rvalid); end
        @(negedge clk);
        mem_if.rvalid = 1'b0;
        #1;
        checks++; if (perr !== 1'b0) begin errors++; $display("FAIL lock_perr got %0h exp 0", perr); end
    endtask

    task automatic test_full_queue();
        apply_reset();
        @(negedge clk);
        instr_if.req = 1'b1; instr_if.addr = 32'h300; mem_if.gnt = 1'b1;
        #1;
        checks++; if (instr_if.gnt !== 1'b1) begin errors++; $display("FAIL full_acc0 got %0h exp 1", instr_if.gnt); end
        @(negedge clk);
        instr_if.req = 1'b0; data_if.req = 1'b1; data_if.addr = 32'h400;
        #1;
        checks++; if (data_if.gnt !== 1'b1) begin errors++; $display("FAIL full_acc1 got %0h exp 1", data_if.gnt); end
        @(negedge clk);
        data_if.req = 1'b0; instr_if.req = 1'b1; instr_if.addr = 32'h500;
        #1;
        checks++; if (mem_if.req !== 1'b0 || instr_if.gnt !== 1'b0) begin errors++; $display("FAIL full_block got %0h/%0h exp 0/0", mem_if.req, instr_if.gnt); end
        @(negedge clk);
        mem_if.rvalid = 1'b1; mem_if.rdata = 32'h1111;
        #1;
        checks++; if (instr_if.rvalid !== 1'b1 || data_if.rvalid !== 1'b0) begin errors++; $display("FAIL full_pop got %0h/%0h exp 1/0", instr_if.rvalid, data_if.rvalid); end
        checks++; if (mem_if.req !== 1'b1 || instr_if.gnt !== 1'b1 || mem_if.addr !== 32'h500) begin errors++; $display("FAIL full_refill got %0h/%0h/%0h exp 1/1/500", mem_if.req, instr_if.gnt, mem_if.addr); end
        @(negedge clk);
        instr_if.req = 1'b0; mem_if.gnt = 1'b0;
        #1;
        checks++; if (data_if.rvalid !== 1'b1 || instr_if.rvalid !== 1'b0) begin errors++; $display("FAIL full_resp1 got %0h/%0h exp 0/1", instr_if.rvalid, data_if.rvalid); end
        @(negedge clk);
        #1;
        checks++; if (instr_if.rvalid !== 1'b1 || data_if.rvalid !== 1'b0) begin errors++; $display("FAIL full_resp2 got %0h/%0h exp 1/0", instr_if.rvalid, data_if.rvalid); end
        @(negedge clk);
        #1;
        checks++; if (instr_if.rvalid !== 1'b0 || data_if.rvalid !== 1'b0) begin errors++; $display("FAIL full_underflow got %0h/%0h exp 0/0", instr_if.rvalid, data_if.rvalid); end
        @(negedge clk);
        mem_if.rvalid = 1'b0; instr_if.req = 1'b1; instr_if.addr = 32'h600; mem_if.gnt = 1'b1;
        #1;
        checks++; if (instr_if.gnt !== 1'b1 || mem_if.addr !== 32'h600) begin errors++; $display("FAIL full_after_underflow got %0h/%0h exp 1/600", instr_if.gnt, mem_if.addr); end
        @(negedge clk);
        instr_if.req = 1'b0; mem_if.gnt = 1'b0; mem_if.rvalid = 1'b1;
        #1;
        checks++; if (instr_if.rvalid !== 1'b1) begin errors++; $display("FAIL full_wrap_resp got %0h exp 1", instr_if.rvalid); end
        @(negedge clk);
        mem_if.rvalid = 1'b0;
    endtask

    task automatic test_protocol();
        logic exp_err;
`ifdef OBI_ARB_PROTO_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        apply_reset();
        @(negedge clk);
        mem_if.rvalid = 1'b1;
        #1;
        checks++; if (perr !== 1'b0 || instr_if.rvalid !== 1'b0) begin errors++; $display("FAIL proto_same_cycle got %0h/%0h exp 0/0", perr, instr_if.rvalid); end
        @(negedge clk);
        mem_if.rvalid = 1'b0;
        #1;
        checks++; if (perr !== exp_err) begin errors++; $display("FAIL proto_stray_rvalid got %0h exp %0h", perr, exp_err); end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (perr !== exp_err) begin errors++; $display("FAIL proto_sticky got %0h exp %0h", perr, exp_err); end
        rst_n = 1'b0;
        #1;
        checks++; if (perr !== 1'b0) begin errors++; $display("FAIL proto_reset_clear got %0h exp 0", perr); end
        @(negedge clk);
        rst_n = 1'b1;
        // Locked requester withdraws its request before grant.
        @(negedge clk);
        data_if.req = 1'b1; data_if.addr = 32'h700;
        #1;
        checks++; if (mem_if.req !== 1'b1 || data_if.gnt !== 1'b0) begin errors++; $display("FAIL proto_lock_req got %0h/%0h exp 1/0", mem_if.req, data_if.gnt); end
        @(negedge clk);
        data_if.req = 1'b0;
        #1;
        checks++; if (mem_if.req !== 1'b0 || perr !== 1'b0) begin errors++; $display("FAIL proto_lock_drop got %0h/%0h exp 0/0", mem_if.req, perr); end
        @(negedge clk);
        instr_if.req = 1'b1; instr_if.addr = 32'h800; mem_if.gnt = 1'b1;
        #1;
        checks++; if (perr !== exp_err) begin errors++; $display("FAIL proto_lock_err got %0h exp %0h", perr, exp_err); end
        checks++; if (instr_if.gnt !== 1'b1 || mem_if.addr !== 32'h800) begin errors++; $display("FAIL proto_lock_release got %0h/%0h exp 1/800", instr_if.gnt, mem_if.addr); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        @(negedge clk);
        instr_if.req = 1'b1; instr_if.addr = 32'h900; mem_if.gnt = 1'b1;
        #1;
        checks++; if (instr_if.gnt !== 1'b1) begin errors++; $display("FAIL midrst_accept got %0h exp 1", instr_if.gnt); end
        @(negedge clk);
        mem_if.rvalid = 1'b1; mem_if.rdata = 32'hCAFE;
        rst_n = 1'b0;
        #1;
        checks++; if (mem_if.req !== 1'b0 || instr_if.gnt !== 1'b0 || mem_if.addr !== 32'h0) begin errors++; $display("FAIL midrst_req got %0h/%0h/%0h exp 0/0/0", mem_if.req, instr_if.gnt, mem_if.addr); end
        checks++; if (instr_if.rvalid !== 1'b0 || data_if.rvalid !== 1'b0 || instr_if.rdata !== 32'h0) begin errors++; $display("FAIL midrst_resp got %0h/%0h/%0h exp 0/0/0", instr_if.rvalid, data_if.rvalid, instr_if.rdata); end
        @(negedge clk);
        rst_n = 1'b1;
        instr_if.req = 1'b0; mem_if.gnt = 1'b0; mem_if.rvalid = 1'b1;
        #1;
        checks++; if (instr_if.rvalid !== 1'b0 || data_if.rvalid !== 1'b0) begin errors++; $display("FAIL midrst_stale_rvalid got %0h/%0h exp 0/0", instr_if.rvalid, data_if.rvalid); end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_contention();
        test_lock();
        test_full_queue();
        test_protocol();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/obi_mem_arbiter.md
Name: obi_mem_arbiter

Overview:
Two-to-one OBI arbiter that shares one single-ported memory/peripheral port between the core instruction fetch interface (requester 0) and the data LSU interface (requester 1).
- Sits between the core and the memory model in the core test subsystem.
- Forwards requests with round-robin priority and keeps an in-order queue of outstanding transaction owners.
- Routes each response (rvalid/rdata) back to the requester that issued it.

Parameters:
ADDR_WIDTH, 32, address width on all ports
DATA_WIDTH, 32, read/write data width on all ports
MAX_OUTSTANDING, 2, depth of the owner queue (power of two, >=1); max in-flight transactions at memory

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
instr_req_i  in  1  fetch request
instr_addr_i  in  ADDR_WIDTH  fetch address
instr_gnt_o  out  1  fetch grant
instr_rvalid_o  out  1  fetch response valid
instr_rdata_o  out  DATA_WIDTH  fetch read data
data_req_i  in  1  LSU request
data_addr_i  in  ADDR_WIDTH  LSU address
data_we_i  in  1  LSU write enable
data_be_i  in  DATA_WIDTH/8  LSU byte enables
data_wdata_i  in  DATA_WIDTH  LSU write data
data_gnt_o  out  1  LSU grant
data_rvalid_o  out  1  LSU response valid
data_rdata_o  out  DATA_WIDTH  LSU read data
mem_req_o  out  1  memory request
mem_addr_o  out  ADDR_WIDTH  memory address
mem_we_o  out  1  memory write enable
mem_be_o  out  DATA_WIDTH/8  memory byte enables
mem_wdata_o  out  DATA_WIDTH  memory write data
mem_gnt_i  in  1  memory grant
mem_rvalid_i  in  1  memory response valid (in order, every transaction incl. writes)
mem_rdata_i  in  DATA_WIDTH  memory read data
protocol_err_o  out  1  sticky protocol-violation flag

Behaviour:
- Clock and reset: clk_i only. rst_ni is asynchronous, active-low; all state clears immediately on assertion.
- Reset values: owner queue empty, rr_ptr=0 (instr favoured), lock=0, protocol_err_o=0. All outputs 0 while rst_ni low.
- Arbitration (combinational on current inputs + state), state IDLE/LOCKED:
  - IDLE, queue not full: select the only requester; if both request, select the one rr_ptr points to. mem_req_o=1.
  - Queue full (count==MAX_OUTSTANDING): mem_req_o=0, no grants; selection deferred.
  - LOCKED: selection is forced to locked_src. OBI requires addr/attrs stable until gnt; no switching.
- Handshake: mem_* mirrors the selected requester. For instr: mem_we_o=0, mem_be_o all-ones, mem_wdata_o=0. The selected gnt_o = mem_gnt_i; the other gnt_o = 0. No added latency on req/gnt path.
- mem_req_o=1 && mem_gnt_i=0: next state LOCKED, locked_src=selected.
- Accepted transfer (mem_req_o && mem_gnt_i):
  - push selected id into owner queue;
  - next state IDLE;
  - rr_ptr <= other requester (flips on every accept, even uncontested).
- Response routing: on mem_rvalid_i, pop queue head.
  - head==0: instr_rvalid_o=1. head==1: data_rvalid_o=1.
  - Both *_rdata_o driven with mem_rdata_i unconditionally; only rvalid is gated.
  - Zero added latency.
- Simultaneous push and pop in one cycle: count unchanged; a full queue may accept a new request in the same cycle as a pop (full test uses count after pop).
- Boundaries:
  - Queue pointers wrap modulo MAX_OUTSTANDING.
  - mem_rvalid_i with empty queue: ignored (no rvalid out, no underflow).

Optional Feature:
- Macro OBI_ARB_PROTO_CHECK_EN.
- Defined: protocol_err_o sets, sticky until reset, on either event:
  - (a) mem_rvalid_i while queue empty;
  - (b) in LOCKED, locked requester drops req or changes addr before gnt.
  - With (b), the arbiter releases the lock and returns to IDLE.
- Undefined: protocol_err_o tied 0. Lock is still released if the locked requester drops req (no hang).

Test Plan:
- Reset mid-transaction: 1 outstanding, assert rst_ni low -> all outputs 0 immediately; after release, first mem_rvalid_i is ignored.
- Single instr fetch:
  - stimulus: instr_req=1, addr 0x180, mem_gnt=1 same cycle; mem_rvalid next cycle with rdata 0xDEADBEEF;
  - required: instr_gnt=1 that cycle, instr_rvalid=1 with 0xDEADBEEF, data_rvalid=0.
- Contention round-robin:
  - stimulus: both req held 4 cycles, mem_gnt=1 constant;
  - required: grants alternate instr, data, instr, data; mem_we follows data_we_i only on data cycles.
- Lock:
  - stimulus: data req, addr 0x1000_0000, mem_gnt=0 for 3 cycles while instr_req=1;
  - required: mem_addr_o stays 0x1000_0000; data_gnt on cycle 4 when mem_gnt=1.
- Full queue (MAX_OUTSTANDING=2):
  - stimulus: 2 accepts, no rvalid; third request held;
  - required: mem_req_o=0. Next cycle mem_rvalid_i=1 -> first owner gets rvalid, third request forwarded and granted same cycle.
- Protocol check (macro defined):
  - stimulus: mem_rvalid_i with empty queue;
  - required: protocol_err_o=1 next cycle and stays 1 until rst_ni low.
